// File: rtl/cp0_except_if.sv
// Commit-stage bundle between the pipeline and the CP0 exception block.
// Latency: none, plain wires; the block's outputs are combinational on these inputs.
// Backpressure: none, the commit stage presents at most one instruction per cycle.
interface cp0_except_if;
   logic        cmt_valid;
   logic [31:0] cmt_pc;
   logic        cmt_bd;
   logic        ex_adel_if;
   logic        ex_ri;
   logic        ex_ov;
   logic        ex_sys;
   logic        ex_bp;
   logic        ex_adel_mem;
   logic        ex_ades;
   logic [31:0] mem_badvaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic        mtc0_we;
   logic [4:0]  c0_addr;
   logic [31:0] c0_wdata;
   logic [31:0] c0_rdata;
   logic        flush;
   logic [31:0] flush_pc;
   logic        int_pending;

   // Pipeline side: drives commit info, receives flush/redirect and mfc0 data.
   modport master (
      output cmt_valid, cmt_pc, cmt_bd, ex_adel_if, ex_ri, ex_ov, ex_sys, ex_bp,
             ex_adel_mem, ex_ades, mem_badvaddr, eret, hw_int, mtc0_we, c0_addr, c0_wdata,
      input  c0_rdata, flush, flush_pc, int_pending
   );

   // CP0 side.
   modport slave (
      input  cmt_valid, cmt_pc, cmt_bd, ex_adel_if, ex_ri, ex_ov, ex_sys, ex_bp,
             ex_adel_mem, ex_ades, mem_badvaddr, eret, hw_int, mtc0_we, c0_addr, c0_wdata,
      output c0_rdata, flush, flush_pc, int_pending
   );
endinterface

// File: rtl/cp0_except.sv
// CP0 exception/interrupt controller: architectural CP0 registers, commit-stage flush and redirect.
// Latency: flush/flush_pc/c0_rdata combinational; register updates land on the next clk edge.
// Backpressure: none. Optional free-running timer enabled by defining CP0_TIMER_EN.
module cp0_except #(
   parameter logic [31:0] EX_VECTOR  = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input logic          clk,
   input logic          reset,
   cp0_except_if.slave  bus
);
   logic [31:0] r_badvaddr;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [7:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip_hw;
   logic [1:0]  r_ip_sw;
   logic [4:0]  r_exccode;
   logic [31:0] r_epc;

   logic        w_ti;
   logic [7:0]  w_ip;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic        w_int_pend;
   logic        w_exc_vld;
   logic [4:0]  w_exc_code;
   logic        w_bad_pc;
   logic        w_bad_mem;
   logic        w_mtc0;
   logic        w_eret;

   // Timer interrupt sits on IP[7] alongside hw_int[5].
   assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
   assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
   assign w_cause  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

   assign w_int_pend = r_ie & ~r_exl & (|(w_ip & r_im));

   // Fixed-priority exception selection at commit; interrupts win over everything.
   always_comb begin
      w_exc_vld  = 1'b0;
      w_exc_code = 5'd0;
      w_bad_pc   = 1'b0;
      w_bad_mem  = 1'b0;
      if (bus.cmt_valid && !reset) begin
         if (w_int_pend) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd0;
         end else if (bus.ex_adel_if) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd4; w_bad_pc = 1'b1;
         end else if (bus.ex_ri) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd10;
         end else if (bus.ex_ov) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd12;
         end else if (bus.ex_sys) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd8;
         end else if (bus.ex_bp) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd9;
         end else if (bus.ex_adel_mem) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd4; w_bad_mem = 1'b1;
         end else if (bus.ex_ades) begin
            w_exc_vld = 1'b1; w_exc_code = 5'd5; w_bad_mem = 1'b1;
         end
      end
   end

   // A taken exception cancels any mtc0/eret riding on the same instruction.
   assign w_mtc0 = bus.cmt_valid & bus.mtc0_we & ~w_exc_vld & ~reset;
   assign w_eret = bus.cmt_valid & bus.eret & ~w_exc_vld & ~reset;

   assign bus.flush       = w_exc_vld | w_eret;
   assign bus.flush_pc    = w_exc_vld ? EX_VECTOR : r_epc;
   assign bus.int_pending = w_int_pend & ~reset;

   // mfc0 read mux; unimplemented registers read as zero.
   always_comb begin
      bus.c0_rdata = 32'd0;
      case (bus.c0_addr)
         5'd8:    bus.c0_rdata = r_badvaddr;
         5'd9:    bus.c0_rdata = r_count;
         5'd11:   bus.c0_rdata = r_compare;
         5'd12:   bus.c0_rdata = w_status;
         5'd13:   bus.c0_rdata = w_cause;
         5'd14:   bus.c0_rdata = r_epc;
         default: bus.c0_rdata = 32'd0;
      endcase
   end

`ifdef CP0_TIMER_EN
   logic r_tick;
   logic r_ti;
   logic w_cnt_wr;
   logic w_cnt_upd;

   assign w_cnt_wr  = w_mtc0 && (bus.c0_addr == 5'd9);
   assign w_cnt_upd = ~r_tick & ~w_cnt_wr;
   assign w_ti      = r_ti;

   // Half-rate tick; Count==Compare on an incrementing cycle raises TI, Compare write clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick <= 1'b0;
         r_ti   <= 1'b0;
      end else begin
         r_tick <= w_cnt_wr ? 1'b0 : ~r_tick;
         if (w_mtc0 && (bus.c0_addr == 5'd11))
            r_ti <= 1'b0;
         else if (w_cnt_upd && (r_count == r_compare))
            r_ti <= 1'b1;
      end
   end
`else
   assign w_ti = 1'b0;
`endif

   // Count/Compare: software writes, plus the increment when the timer is built in.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= 32'd0;
         r_compare <= 32'd0;
      end else begin
         if (w_mtc0 && (bus.c0_addr == 5'd9))
            r_count <= bus.c0_wdata;
`ifdef CP0_TIMER_EN
         else if (w_cnt_upd)
            r_count <= r_count + 32'd1;
`endif
         if (w_mtc0 && (bus.c0_addr == 5'd11))
            r_compare <= bus.c0_wdata;
      end
   end

   // Status/Cause/EPC/BadVAddr: exception entry, eret, mtc0 and interrupt line sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im       <= STATUS_RST[15:8];
         r_exl      <= STATUS_RST[1];
         r_ie       <= STATUS_RST[0];
         r_bd       <= 1'b0;
         r_ip_hw    <= 6'd0;
         r_ip_sw    <= 2'd0;
         r_exccode  <= 5'd0;
         r_epc      <= 32'd0;
         r_badvaddr <= 32'd0;
      end else begin
         r_ip_hw <= bus.hw_int;
         if (w_exc_vld) begin
            r_exccode <= w_exc_code;
            r_exl     <= 1'b1;
            // Nested exceptions keep the original return point.
            if (!r_exl) begin
               r_epc <= bus.cmt_bd ? (bus.cmt_pc - 32'd4) : bus.cmt_pc;
               r_bd  <= bus.cmt_bd;
            end
            if (w_bad_pc)
               r_badvaddr <= bus.cmt_pc;
            else if (w_bad_mem)
               r_badvaddr <= bus.mem_badvaddr;
         end else begin
            if (w_mtc0) begin
               case (bus.c0_addr)
                  5'd12: begin
                     r_im  <= bus.c0_wdata[15:8];
                     r_exl <= bus.c0_wdata[1];
                     r_ie  <= bus.c0_wdata[0];
                  end
                  5'd13:   r_ip_sw <= bus.c0_wdata[9:8];
                  5'd14:   r_epc   <= bus.c0_wdata;
                  default: ;
               endcase
            end
            // eret already redirected to the old EPC; only EXL changes here.
            if (w_eret)
               r_exl <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cp0_except.sv
// Self-checking bench for cp0_except: reference model computes expected outputs per cycle
// into a queue; a negedge monitor pops and compares against the DUT.
// Directed scenarios first, then randomized commit traffic with occasional resets.
module tb_cp0_except;
   localparam logic [31:0] VEC  = 32'hBFC0_0380;
   localparam logic [31:0] SRST = 32'h0040_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cp0_except_if bus ();

   cp0_except #(.EX_VECTOR(VEC), .STATUS_RST(SRST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        flush;
      logic [31:0] fpc;
      logic [31:0] rd;
      logic        ipend;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Stimulus for the current cycle.
   logic        s_reset, s_valid, s_bd, s_eret, s_we;
   logic        s_adel_if, s_ri, s_ov, s_sys, s_bp, s_adel_mem, s_ades;
   logic [31:0] s_pc, s_badv, s_wdata;
   logic [5:0]  s_hw;
   logic [4:0]  s_addr;

   // Reference model: CP0 registers kept as full architectural 32-bit words.
   logic [31:0] m_reg [32];
   logic [5:0]  m_hw;
   logic        m_ti;
   logic        m_tick;
   logic        m_known = 1'b0;

   function automatic logic [31:0] wmask(input logic [4:0] a);
      case (a)
         5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
         5'd12:              return 32'h0000_FF03;
         5'd13:              return 32'h0000_0300;
         default:            return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] a);
      logic [5:0] hip;
      hip = {m_hw[5] | m_ti, m_hw[4:0]};
      if (a == 5'd13)
         return m_reg[13] | (32'(m_ti) << 30) | (32'(hip) << 10);
      return m_reg[a];
   endfunction

   task automatic model_cycle();
      logic [7:0]  ip;
      logic        ipend, exc, old_exl, f;
      logic [4:0]  code;
      int          sel;
      logic        pri [8];
      int          codes [8];
      logic [31:0] mk, fpc;
      exp_t        e;
      codes = '{0, 4, 10, 12, 8, 9, 4, 5};
      ip    = {m_hw[5] | m_ti, m_hw[4:0], m_reg[13][9:8]};
      ipend = !s_reset && m_reg[12][0] && !m_reg[12][1] && ((ip & m_reg[12][15:8]) != 8'd0);
      pri   = '{ipend, s_adel_if, s_ri, s_ov, s_sys, s_bp, s_adel_mem, s_ades};
      exc = 1'b0; code = 5'd0; sel = -1;
      if (!s_reset && s_valid)
         for (int i = 0; i < 8; i++)
            if (!exc && pri[i]) begin
               exc = 1'b1; code = 5'(codes[i]); sel = i;
            end
      f   = !s_reset && s_valid && (exc || s_eret);
      fpc = exc ? VEC : m_reg[14];
      e = '{f, fpc, rd_reg(s_addr), ipend, cyc};
      if (m_known) q.push_back(e);

      if (s_reset) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         m_reg[12] = SRST;
         m_hw = 6'd0; m_ti = 1'b0; m_tick = 1'b0; m_known = 1'b1;
      end else begin
`ifdef CP0_TIMER_EN
         begin
            logic cwr;
            cwr = s_valid && s_we && !exc && (s_addr == 5'd9);
            if (!m_tick && !cwr) begin
               if (m_reg[9] == m_reg[11]) m_ti = 1'b1;
               m_reg[9] = m_reg[9] + 32'd1;
            end
            m_tick = cwr ? 1'b0 : !m_tick;
         end
`endif
         if (exc) begin
            old_exl = m_reg[12][1];
            m_reg[13][6:2] = code;
            m_reg[12][1]   = 1'b1;
            if (!old_exl) begin
               m_reg[14]     = s_bd ? s_pc - 32'd4 : s_pc;
               m_reg[13][31] = s_bd;
            end
            if (sel == 1) m_reg[8] = s_pc;
            if (sel == 6 || sel == 7) m_reg[8] = s_badv;
         end else if (s_valid) begin
            if (s_we) begin
               mk = wmask(s_addr);
               m_reg[s_addr] = (m_reg[s_addr] & ~mk) | (s_wdata & mk);
`ifdef CP0_TIMER_EN
               if (s_addr == 5'd11) m_ti = 1'b0;
`endif
            end
            if (s_eret) m_reg[12][1] = 1'b0;
         end
         m_hw = s_hw;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      reset            = s_reset;
      bus.cmt_valid    = s_valid;
      bus.cmt_pc       = s_pc;
      bus.cmt_bd       = s_bd;
      bus.ex_adel_if   = s_adel_if;
      bus.ex_ri        = s_ri;
      bus.ex_ov        = s_ov;
      bus.ex_sys       = s_sys;
      bus.ex_bp        = s_bp;
      bus.ex_adel_mem  = s_adel_mem;
      bus.ex_ades      = s_ades;
      bus.mem_badvaddr = s_badv;
      bus.eret         = s_eret;
      bus.hw_int       = s_hw;
      bus.mtc0_we      = s_we;
      bus.c0_addr      = s_addr;
      bus.c0_wdata     = s_wdata;
      cyc++;
      model_cycle();
   endtask

   task automatic idle();
      s_reset = 0; s_valid = 0; s_pc = 0; s_bd = 0; s_eret = 0; s_we = 0;
      s_adel_if = 0; s_ri = 0; s_ov = 0; s_sys = 0; s_bp = 0; s_adel_mem = 0; s_ades = 0;
      s_badv = 0; s_wdata = 0; s_hw = 0; s_addr = 5'd12;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      idle(); s_valid = 1; s_we = 1; s_addr = a; s_wdata = d; step();
   endtask

   task automatic rd(input logic [4:0] a);
      idle(); s_addr = a; step();
   endtask

   task automatic commit(input logic [31:0] pc, input logic bd, input logic [4:0] a);
      s_valid = 1; s_pc = pc; s_bd = bd; s_addr = a; step();
   endtask

   // Monitor: compares DUT outputs against the queued expectations away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (bus.flush !== e.flush) begin
               bad++;
               $display("FAIL flush cyc=%0d got=%b exp=%b", e.cyc, bus.flush, e.flush);
            end
            if (e.flush) begin
               total++;
               if (bus.flush_pc !== e.fpc) begin
                  bad++;
                  $display("FAIL flush_pc cyc=%0d got=%h exp=%h", e.cyc, bus.flush_pc, e.fpc);
               end
            end
            total++;
            if (bus.c0_rdata !== e.rd) begin
               bad++;
               $display("FAIL c0_rdata cyc=%0d addr=%0d got=%h exp=%h", e.cyc, bus.c0_addr, bus.c0_rdata, e.rd);
            end
            total++;
            if (bus.int_pending !== e.ipend) begin
               bad++;
               $display("FAIL int_pending cyc=%0d got=%b exp=%b", e.cyc, bus.int_pending, e.ipend);
            end
         end
      end
   end

   initial begin
      logic [4:0] addrs [7];
      int r;
      idle();
      s_reset = 1;
      reset = 1;
      bus.cmt_valid = 0; bus.cmt_pc = 0; bus.cmt_bd = 0; bus.ex_adel_if = 0; bus.ex_ri = 0;
      bus.ex_ov = 0; bus.ex_sys = 0; bus.ex_bp = 0; bus.ex_adel_mem = 0; bus.ex_ades = 0;
      bus.mem_badvaddr = 0; bus.eret = 0; bus.hw_int = 0; bus.mtc0_we = 0; bus.c0_addr = 5'd12;
      bus.c0_wdata = 0;

      // Reset, with flags asserted to show they are ignored.
      step();
      s_valid = 1; s_ov = 1; s_eret = 1; step();
      idle(); s_reset = 1; s_addr = 5'd13; step();
      rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd3);

      // Overflow, not in a delay slot.
      idle(); s_ov = 1; commit(32'h8000_0010, 0, 5'd14);
      rd(5'd14); rd(5'd13); rd(5'd12);
      mtc0(5'd12, SRST);

      // Overflow in a delay slot, then a nested syscall.
      idle(); s_ov = 1; commit(32'h8000_0010, 1, 5'd13);
      rd(5'd14); rd(5'd13);
      idle(); s_sys = 1; commit(32'h8000_0200, 0, 5'd14);
      rd(5'd14); rd(5'd13);
      mtc0(5'd12, SRST);

      // Ov beats AdES; AdES alone records BadVAddr.
      idle(); s_ov = 1; s_ades = 1; s_badv = 32'h2002; commit(32'h8000_0020, 0, 5'd8);
      rd(5'd13); rd(5'd8);
      mtc0(5'd12, SRST);
      idle(); s_ades = 1; s_badv = 32'h1001; commit(32'h8000_0024, 0, 5'd8);
      rd(5'd13); rd(5'd8);
      idle(); s_adel_if = 1; commit(32'h8000_0031, 0, 5'd8);
      rd(5'd8);
      mtc0(5'd12, SRST);

      // eret flow, eret vs exception, mtc0 EPC together with eret.
      mtc0(5'd14, 32'h8000_0100);
      mtc0(5'd12, SRST | 32'h2);
      idle(); s_eret = 1; commit(32'h8000_0040, 0, 5'd14);
      rd(5'd12);
      idle(); s_eret = 1; s_sys = 1; commit(32'h8000_0044, 0, 5'd13);
      rd(5'd13); rd(5'd12);
      idle(); s_eret = 1; s_we = 1; s_wdata = 32'h8000_0500; commit(32'h8000_0048, 0, 5'd14);
      rd(5'd14); rd(5'd12);

      // Exception suppresses mtc0; cmt_valid=0 ignores everything.
      idle(); s_bp = 1; s_we = 1; s_wdata = 32'h1234_5678; commit(32'h8000_0050, 0, 5'd14);
      rd(5'd14);
      mtc0(5'd12, SRST);
      idle(); s_ri = 1; s_eret = 1; s_we = 1; s_addr = 5'd14; s_wdata = 32'hDEAD_BEEF; step();
      rd(5'd14); rd(5'd12);

      // Unimplemented and read-only registers ignore writes.
      mtc0(5'd8, 32'hFFFF_FFFF); rd(5'd8);
      mtc0(5'd5, 32'hFFFF_FFFF); rd(5'd5);
      mtc0(5'd13, 32'hFFFF_FFFF); rd(5'd13);
      mtc0(5'd12, 32'hFFFF_FFFF); rd(5'd12);
      mtc0(5'd12, SRST); mtc0(5'd13, 32'h0);

      // Hardware interrupt on IP[2] (bit 10), then taken at next commit.
      mtc0(5'd12, 32'h0040_0401);
      idle(); s_hw = 6'b000001; s_addr = 5'd13; step();
      idle(); s_hw = 6'b000001; s_addr = 5'd13; step();
      idle(); s_hw = 6'b000001; s_ri = 1; commit(32'h8000_0060, 0, 5'd13);
      rd(5'd13); rd(5'd14);
      // Software interrupt via Cause.IP[0].
      mtc0(5'd12, 32'h0040_0101);
      mtc0(5'd13, 32'h0000_0100);
      idle(); commit(32'h8000_0070, 1, 5'd13);
      rd(5'd14);
      mtc0(5'd13, 32'h0); mtc0(5'd12, SRST);

      // Count/Compare plain R/W and timer behaviour.
      mtc0(5'd12, 32'h0040_8001);
      mtc0(5'd9, 32'd5);
      mtc0(5'd11, 32'd8);
      for (int i = 0; i < 8; i++) rd(5'd13);
      idle(); commit(32'h8000_0080, 0, 5'd13);
      rd(5'd13); rd(5'd9);
      mtc0(5'd11, 32'd100);
      rd(5'd13);
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd(5'd9); rd(5'd9); rd(5'd9);
      mtc0(5'd12, SRST);

      // Randomized commit traffic.
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      for (int n = 0; n < 3000; n++) begin
         idle();
         r = $urandom_range(0, 99);
         s_reset    = (r < 1);
         s_valid    = ($urandom_range(0, 9) < 7);
         s_pc       = {$urandom} & 32'hFFFF_FFFC;
         s_bd       = $urandom_range(0, 1);
         s_adel_if  = ($urandom_range(0, 15) == 0);
         s_ri       = ($urandom_range(0, 15) == 0);
         s_ov       = ($urandom_range(0, 15) == 0);
         s_sys      = ($urandom_range(0, 15) == 0);
         s_bp       = ($urandom_range(0, 15) == 0);
         s_adel_mem = ($urandom_range(0, 15) == 0);
         s_ades     = ($urandom_range(0, 15) == 0);
         s_badv     = $urandom;
         s_eret     = ($urandom_range(0, 7) == 0);
         s_hw       = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
         s_we       = ($urandom_range(0, 3) == 0);
         s_addr     = addrs[$urandom_range(0, 6)];
         if (s_addr == 5'd0) s_addr = 5'($urandom);
         s_wdata    = $urandom;
         step();
      end

      idle(); step();
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
